// File: rtl/wb_commit_buffer.sv
// In-order writeback commit FIFO between the memory stage and the register-file write port.
// Define WB_FWD_EN to build the pending-result lookup ports (fwd_*) for decode.
module wb_commit_buffer #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_data,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [XLEN-1:0]  link_data,
  input  logic [1:0]       src_sel,
  input  logic             reg_write,
  input  logic [RA_W-1:0]  rd,
  output logic             rf_valid,
  input  logic             rf_ready,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] count
`ifdef WB_FWD_EN
  ,
  input  logic [RA_W-1:0]  fwd_rs1,
  input  logic [RA_W-1:0]  fwd_rs2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [XLEN-1:0]  fwd_data1,
  output logic [XLEN-1:0]  fwd_data2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [RA_W-1:0]  rdMem   [DEPTH];
  logic [XLEN-1:0]  dataMem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic             inFire;
  logic             outFire;
  logic             doEnq;
  logic [XLEN-1:0]  inData;

  assign rf_valid = (count != '0);
  // Head outputs are zeroed while empty so stale entries never appear on the write port.
  assign rf_waddr = rf_valid ? rdMem[headPtr]   : '0;
  assign rf_wdata = rf_valid ? dataMem[headPtr] : '0;

  always_comb begin
    outFire  = rf_valid & rf_ready;
    in_ready = (count < CNT_W'(DEPTH)) | outFire;
    inFire   = in_valid & in_ready;
    doEnq    = inFire & reg_write & (rd != '0) & (src_sel != 2'b11);
    inData   = '0;
    case (src_sel)
      2'b00:   inData = alu_data;
      2'b01:   inData = mem_data;
      2'b10:   inData = link_data;
      default: inData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdMem[i]   <= '0;
        dataMem[i] <= '0;
      end
    end else begin
      if (doEnq) begin
        rdMem[tailPtr]   <= rd;
        dataMem[tailPtr] <= inData;
        tailPtr          <= tailPtr + 1'b1;
      end
      if (outFire) begin
        headPtr <= headPtr + 1'b1;
      end
      case ({doEnq, outFire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match wins; only occupied slots are considered.
  function automatic logic [XLEN:0] lookup(input logic [RA_W-1:0] rs);
    logic [XLEN:0]    result;
    logic [PTR_W-1:0] idx;
    result = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (rs != '0) && (rdMem[idx] == rs)) begin
        result = {1'b1, dataMem[idx]};
      end
    end
    return result;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_rs1);
    {fwd_hit2, fwd_data2} = lookup(fwd_rs2);
  end
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Scoreboard bench for wb_commit_buffer: a driver pushes expected writes into a queue,
// a negedge monitor checks the write port, occupancy, handshake and (optionally) forwarding.
module tb_wb_commit_buffer;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  typedef struct {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic             clk = 0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  alu_data, mem_data, link_data;
  logic [1:0]       src_sel;
  logic             reg_write;
  logic [RA_W-1:0]  rd;
  logic             rf_valid;
  logic             rf_ready;
  logic [RA_W-1:0]  rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic [CNT_W-1:0] count;
  logic [RA_W-1:0]  fwd_rs1, fwd_rs2;
`ifdef WB_FWD_EN
  logic             fwd_hit1, fwd_hit2;
  logic [XLEN-1:0]  fwd_data1, fwd_data2;
`endif

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic chkZero = 0;

  always #5 clk = ~clk;

  wb_commit_buffer #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_data(alu_data), .mem_data(mem_data), .link_data(link_data),
    .src_sel(src_sel), .reg_write(reg_write), .rd(rd),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .count(count)
`ifdef WB_FWD_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Youngest pending write to rs, as decode would see it.
  function automatic logic [XLEN:0] modelFwd(input logic [RA_W-1:0] rs);
    if (rs == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == rs) return {1'b1, q[i].data};
    return '0;
  endfunction

  always @(negedge clk) begin
    int n;
    logic [XLEN:0] f;
    if (!reset) begin
      n = q.size();
      chk("count", count, n);
      chk("rf_valid", rf_valid, n != 0);
      chk("in_ready", in_ready, (n < DEPTH) || (n != 0 && rf_ready));
      if (n != 0) begin
        chk("rf_waddr", rf_waddr, q[0].rd);
        chk("rf_wdata", rf_wdata, q[0].data);
      end
      if (chkZero) begin
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
      end
`ifdef WB_FWD_EN
      f = modelFwd(fwd_rs1);
      chk("fwd_hit1", fwd_hit1, f[XLEN]);
      if (f[XLEN]) chk("fwd_data1", fwd_data1, f[XLEN-1:0]);
      f = modelFwd(fwd_rs2);
      chk("fwd_hit2", fwd_hit2, f[XLEN]);
      if (f[XLEN]) chk("fwd_data2", fwd_data2, f[XLEN-1:0]);
`endif
      if (rf_valid && rf_ready && n != 0) void'(q.pop_front());
    end
  end

  // One clock: note acceptance at negedge, commit the expected entry just after posedge.
  task automatic step(output logic acc);
    logic store;
    ent_t e;
    @(negedge clk);
    acc   = in_valid && in_ready && !reset;
    store = acc && reg_write && (rd != 0) && (src_sel != 2'b11);
    e.rd  = rd;
    e.data = (src_sel == 2'b00) ? alu_data : (src_sel == 2'b01) ? mem_data : link_data;
    @(posedge clk);
    #1;
    chkZero = reset;
    if (reset) q.delete();
    else if (store) q.push_back(e);
  endtask

  task automatic put(input logic v, input logic [1:0] s, input logic rw, input logic [RA_W-1:0] r,
                     input logic [XLEN-1:0] d, input logic rfr);
    logic acc;
    in_valid = v; src_sel = s; reg_write = rw; rd = r; rf_ready = rfr;
    alu_data = d; mem_data = d ^ 32'h5A5A_0000; link_data = d + 4;
    if (s == 2'b01) mem_data = d;
    if (s == 2'b10) link_data = d;
    step(acc);
  endtask

  initial begin
    logic acc;
    reset = 1; in_valid = 0; alu_data = 0; mem_data = 0; link_data = 0;
    src_sel = 0; reg_write = 0; rd = 0; rf_ready = 0; fwd_rs1 = 0; fwd_rs2 = 0;
    step(acc); step(acc);
    reset = 0;
    put(0, 0, 0, 0, 0, 1);

    put(1, 2'b00, 1, 5, 32'h11, 1);
    put(0, 0, 0, 0, 0, 1);
    put(0, 0, 0, 0, 0, 1);

    put(1, 2'b01, 1, 3, 32'hDEADBEEF, 1);
    put(1, 2'b10, 1, 1, 32'h104, 1);
    repeat (3) put(0, 0, 0, 0, 0, 1);

    put(1, 2'b00, 1, 0, 32'h77, 1);
    put(1, 2'b11, 1, 7, 32'h88, 1);
    put(1, 2'b00, 0, 6, 32'h99, 1);
    put(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) put(1, 2'b00, 1, 5'(10 + i), 32'(32'h100 + i), 0);
    put(1, 2'b00, 1, 14, 32'h104, 0);
    put(1, 2'b00, 1, 14, 32'h104, 1);
    repeat (6) put(0, 0, 0, 0, 0, 1);

    put(1, 2'b00, 1, 9, 32'hA, 0);
    put(1, 2'b00, 1, 9, 32'hB, 0);
    fwd_rs1 = 9; fwd_rs2 = 0;
    put(0, 0, 0, 0, 0, 0);
    fwd_rs2 = 9;
    put(0, 0, 0, 0, 0, 1);
    repeat (2) put(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++) put(1, 2'b00, 1, 5'(20 + i), 32'(32'h300 + i), 0);
    reset = 1;
    put(1, 2'b00, 1, 23, 32'h303, 1);
    reset = 0;
    repeat (2) put(0, 0, 0, 0, 0, 1);

    in_valid = 0;
    for (int c = 0; c < 800; c++) begin
      if (!(in_valid && !acc)) begin
        in_valid  = ($urandom_range(3) != 0);
        src_sel   = 2'($urandom_range(3));
        reg_write = ($urandom_range(4) != 0);
        rd        = 5'($urandom_range(7));
        alu_data  = $urandom; mem_data = $urandom; link_data = $urandom;
      end
      rf_ready = ($urandom_range(4) > 1);
      fwd_rs1  = 5'($urandom_range(7));
      fwd_rs2  = 5'($urandom_range(7));
      reset    = ($urandom_range(149) == 0);
      step(acc);
    end
    reset = 0;

    in_valid = 0; rf_ready = 1;
    for (int c = 0; c < 20 && q.size() != 0; c++) step(acc);
    chk("drain", q.size(), 0);
    step(acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
